// File: rtl/ctr_game_driver.sv
// rtl/ctr_game_driver.sv - synthesizable stimulus driver and response checker for the counter game
//
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   start                 : one-cycle pulse, starts a game when idle
//   cfg_init_value        : value loaded into the game via INIT (sampled at start)
//   cfg_control           : count mode 00=+1 01=+2 10=-1 11=-2 (sampled at start)
//   cfg_max_cycles        : RUN-cycle budget, 0 = unlimited (sampled at start)
//   INIT, initial_value   : load request and load value towards the game
//   control               : count mode towards the game
//   counter, WINNER, LOSER, GAMEOVER, WHO : observed game responses
//   busy                  : high from LOAD through CHECK
//   done                  : one-cycle pulse on entry to DONE
//   result                : latched WHO, 11 = timeout, 00 = none yet
//   win_count, lose_count : own saturating tallies of WINNER / LOSER pulses
//   mismatch              : sticky error flag, cleared by the next start
//   cycle_count           : cycles spent in RUN
module ctr_game_driver #(
   parameter int COUNTER_SIZE = 3,
   parameter int TALLY_LIMIT  = 15,
   parameter int TIMEOUT_W    = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [COUNTER_SIZE-1:0] cfg_init_value,
   input  logic [1:0]              cfg_control,
   input  logic [TIMEOUT_W-1:0]    cfg_max_cycles,
   output logic                    INIT,
   output logic [COUNTER_SIZE-1:0] initial_value,
   output logic [1:0]              control,
   input  logic [COUNTER_SIZE-1:0] counter,
   input  logic                    WINNER,
   input  logic                    LOSER,
   input  logic                    GAMEOVER,
   input  logic [1:0]              WHO,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              result,
   output logic [3:0]              win_count,
   output logic [3:0]              lose_count,
   output logic                    mismatch,
   output logic [TIMEOUT_W-1:0]    cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_RUN,
      S_CHECK,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic                    init_q, init_d;
   logic [COUNTER_SIZE-1:0] ival_q, ival_d;
   logic [1:0]              ctrl_q, ctrl_d;
   logic [TIMEOUT_W-1:0]    max_q, max_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [1:0]              result_q, result_d;
   logic [3:0]              win_q, win_d;
   logic [3:0]              lose_q, lose_d;
   logic                    mm_q, mm_d;
   logic [TIMEOUT_W-1:0]    cyc_q, cyc_d;
   logic [COUNTER_SIZE-1:0] prev_q, prev_d;
   logic                    go_q, go_d;

   logic [COUNTER_SIZE-1:0] step;
   logic [COUNTER_SIZE-1:0] expected;
   logic [TIMEOUT_W-1:0]    cyc_inc;

   // Step in two's complement so the down-count modes wrap naturally.
   always_comb begin
      step = '0;
      case (ctrl_q)
         2'b00:   step = COUNTER_SIZE'(1);
         2'b01:   step = COUNTER_SIZE'(2);
         2'b10:   step = '1;
         default: step = {{(COUNTER_SIZE-1){1'b1}}, 1'b0};
      endcase
   end

   // After a GAMEOVER cycle the game clears its counter rather than stepping.
   assign expected = go_q ? '0 : prev_q + step;
   assign cyc_inc  = cyc_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d  = state_q;
      ival_d   = ival_q;
      ctrl_d   = ctrl_q;
      max_d    = max_q;
      result_d = result_q;
      win_d    = win_q;
      lose_d   = lose_q;
      mm_d     = mm_q;
      cyc_d    = cyc_q;
      prev_d   = prev_q;
      go_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ival_d   = cfg_init_value;
               ctrl_d   = cfg_control;
               max_d    = cfg_max_cycles;
               result_d = 2'b00;
               win_d    = '0;
               lose_d   = '0;
               mm_d     = 1'b0;
               cyc_d    = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            prev_d  = counter;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (WINNER && (win_q != 4'hF)) begin
               win_d = win_q + 4'd1;
            end
            if (LOSER && (lose_q != 4'hF)) begin
               lose_d = lose_q + 4'd1;
            end
            if ((counter != expected) || (WINNER && LOSER)) begin
               mm_d = 1'b1;
            end
            prev_d = counter;
            go_d   = GAMEOVER;
            cyc_d  = cyc_inc;
            if (GAMEOVER) begin
               result_d = WHO;
               state_d  = S_CHECK;
            end else if ((max_q != '0) && (cyc_inc == max_q)) begin
               result_d = 2'b11;
               state_d  = S_DONE;
            end
         end
         S_CHECK: begin
            // Tallies already include any pulse that arrived with GAMEOVER.
            if (!(((result_q == 2'b01) && (lose_q == 4'(TALLY_LIMIT))) ||
                  ((result_q == 2'b10) && (win_q == 4'(TALLY_LIMIT))))) begin
               mm_d = 1'b1;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the next state.
      init_d = (state_d == S_LOAD);
      busy_d = (state_d == S_LOAD) || (state_d == S_SETTLE) ||
               (state_d == S_RUN)  || (state_d == S_CHECK);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         init_q   <= 1'b0;
         ival_q   <= '0;
         ctrl_q   <= 2'b00;
         max_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 2'b00;
         win_q    <= '0;
         lose_q   <= '0;
         mm_q     <= 1'b0;
         cyc_q    <= '0;
         prev_q   <= '0;
         go_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         init_q   <= init_d;
         ival_q   <= ival_d;
         ctrl_q   <= ctrl_d;
         max_q    <= max_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
         mm_q     <= mm_d;
         cyc_q    <= cyc_d;
         prev_q   <= prev_d;
         go_q     <= go_d;
      end
   end

   assign INIT          = init_q;
   assign initial_value = ival_q;
   assign control       = ctrl_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign result        = result_q;
   assign win_count     = win_q;
   assign lose_count    = lose_q;
   assign mismatch      = mm_q;
   assign cycle_count   = cyc_q;

endmodule

// File: tb/tb_ctr_game_driver.sv
// tb/tb_ctr_game_driver.sv - directed self-checking bench for ctr_game_driver
module tb_ctr_game_driver;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  cfg_init_value = '0;
   logic [1:0]  cfg_control = '0;
   logic [15:0] cfg_max_cycles = '0;
   logic        INIT;
   logic [2:0]  initial_value;
   logic [1:0]  control;
   logic [2:0]  counter;
   logic        WINNER, LOSER, GAMEOVER;
   logic [1:0]  WHO;
   logic        busy, done, mismatch;
   logic [1:0]  result;
   logic [3:0]  win_count, lose_count;
   logic [15:0] cycle_count;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   ctr_game_driver #(.COUNTER_SIZE(3), .TALLY_LIMIT(15), .TIMEOUT_W(16)) dut (
      .clock(clock), .reset(reset), .start(start),
      .cfg_init_value(cfg_init_value), .cfg_control(cfg_control),
      .cfg_max_cycles(cfg_max_cycles),
      .INIT(INIT), .initial_value(initial_value), .control(control),
      .counter(counter), .WINNER(WINNER), .LOSER(LOSER),
      .GAMEOVER(GAMEOVER), .WHO(WHO),
      .busy(busy), .done(done), .result(result),
      .win_count(win_count), .lose_count(lose_count),
      .mismatch(mismatch), .cycle_count(cycle_count)
   );

   // Behavioural counter game: WINNER at all ones, LOSER at zero,
   // GAMEOVER combinationally when a tally reaches 15.
   logic [2:0] g_cnt = '0;
   logic       g_active = 1'b0;
   logic       g_settle = 1'b0;
   logic       g_skipped = 1'b0;
   int         g_win = 0;
   int         g_lose = 0;
   bit         hold = 1'b0;
   bit         skip_en = 1'b0;

   function automatic logic [2:0] stepv(input logic [1:0] m);
      case (m)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         2'b10:   return 3'd7;
         default: return 3'd6;
      endcase
   endfunction

   assign counter  = g_cnt;
   assign WINNER   = g_active && !g_settle && !hold && (g_cnt == 3'd7);
   assign LOSER    = g_active && !g_settle && !hold && (g_cnt == 3'd0);
   assign GAMEOVER = g_active && (((g_win + int'(WINNER)) >= 15) || ((g_lose + int'(LOSER)) >= 15));
   assign WHO      = !GAMEOVER ? 2'b00 : (((g_win + int'(WINNER)) >= 15) ? 2'b10 : 2'b01);

   always @(posedge clock) begin
      g_settle <= INIT;
      if (INIT) begin
         g_cnt     <= initial_value;
         g_active  <= 1'b1;
         g_win     <= 0;
         g_lose    <= 0;
         g_skipped <= 1'b0;
      end else if (g_active) begin
         if (GAMEOVER) begin
            g_active <= 1'b0;
            g_cnt    <= '0;
         end else begin
            if (skip_en && !g_skipped && !g_settle && (g_cnt == 3'd3)) begin
               g_cnt     <= g_cnt + stepv(control) + 3'd1;
               g_skipped <= 1'b1;
            end else begin
               g_cnt <= g_cnt + stepv(control);
            end
            if (WINNER) g_win <= g_win + 1;
            if (LOSER)  g_lose <= g_lose + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_game(input logic [2:0] iv, input logic [1:0] cm, input logic [15:0] mx);
      @(negedge clock);
      cfg_init_value = iv;
      cfg_control    = cm;
      cfg_max_cycles = mx;
      start          = 1'b1;
      @(negedge clock);
      start          = 1'b0;
   endtask

   task automatic wait_done(output int pulses);
      int n;
      n = 0;
      pulses = 0;
      while ((n < 400) && (pulses == 0)) begin
         @(negedge clock);
         n++;
         if (done) pulses++;
      end
      @(negedge clock);
      if (done) pulses++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int p;

      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("rst_flags", {INIT, busy, done, mismatch, result}, 0);
      check("rst_tally", {win_count, lose_count}, 0);
      check("rst_cfgout", {initial_value, control}, 0);
      check("rst_cycles", cycle_count, 0);

      // init 0, +2: only losses
      start_game(3'd0, 2'b01, 16'd0);
      check("t1_init", INIT, 1);
      check("t1_busy", busy, 1);
      wait_done(p);
      check("t1_done", p, 1);
      check("t1_result", result, 2'b01);
      check("t1_lose", lose_count, 15);
      check("t1_win", win_count, 0);
      check("t1_mm", mismatch, 0);
      check("t1_cycles", cycle_count, 60);
      check("t1_busy_end", busy, 0);

      // init 1, +2: only wins
      start_game(3'd1, 2'b01, 16'd0);
      wait_done(p);
      check("t2_done", p, 1);
      check("t2_result", result, 2'b10);
      check("t2_win", win_count, 15);
      check("t2_lose", lose_count, 0);
      check("t2_mm", mismatch, 0);
      check("t2_cycles", cycle_count, 59);

      // init 5, -1: wrap 0->7, losses reach 15 first
      start_game(3'd5, 2'b10, 16'd0);
      wait_done(p);
      check("t3_done", p, 1);
      check("t3_result", result, 2'b01);
      check("t3_lose", lose_count, 15);
      check("t3_win", win_count, 14);
      check("t3_mm", mismatch, 0);
      check("t3_cycles", cycle_count, 117);

      // counter skips 3->5 with +1
      skip_en = 1'b1;
      start_game(3'd0, 2'b00, 16'd0);
      wait_done(p);
      skip_en = 1'b0;
      check("t4_done", p, 1);
      check("t4_mm", mismatch, 1);
      check("t4_result", result, 2'b10);
      check("t4_win", win_count, 15);

      // timeout with game held; start mid-RUN ignored
      hold = 1'b1;
      start_game(3'd2, 2'b00, 16'd20);
      check("t5_mm_cleared", mismatch, 0);
      repeat (5) @(negedge clock);
      cfg_init_value = 3'd6;
      cfg_control    = 2'b11;
      start          = 1'b1;
      @(negedge clock);
      start          = 1'b0;
      check("t5_nostart_init", INIT, 0);
      check("t5_nostart_busy", busy, 1);
      check("t5_nostart_ival", initial_value, 3'd2);
      check("t5_nostart_ctrl", control, 2'b00);
      wait_done(p);
      hold = 1'b0;
      check("t5_done", p, 1);
      check("t5_result", result, 2'b11);
      check("t5_cycles", cycle_count, 20);
      check("t5_mm", mismatch, 0);

      // asynchronous reset during RUN
      start_game(3'd0, 2'b01, 16'd0);
      repeat (10) @(negedge clock);
      check("t6_pre_lose", lose_count, 2);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_flags", {INIT, busy, done, mismatch, result}, 0);
      check("t6_rst_tally", {win_count, lose_count}, 0);
      check("t6_rst_cfgout", {initial_value, control}, 0);
      check("t6_rst_cycles", cycle_count, 0);
      @(negedge clock);
      reset = 1'b0;
      start_game(3'd0, 2'b01, 16'd0);
      check("t6_init_hi", INIT, 1);
      @(negedge clock);
      check("t6_init_lo", INIT, 0);
      wait_done(p);
      check("t6_done", p, 1);
      check("t6_result", result, 2'b01);
      check("t6_lose", lose_count, 15);
      check("t6_mm", mismatch, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctr_game_driver.md
Name: ctr_game_driver

Overview:
- Drives the counter game's control side and checks the game's responses.
- Issues INIT with an initial value, then holds a programmed count mode on control until the game ends.
- Monitors counter, WINNER, LOSER, GAMEOVER and WHO against its own reference model.
- Reports the outcome, its own win/loss tallies and a sticky mismatch flag; it sits opposite the counter game on the same interface and is used as a synthesizable stimulus/checker.

Parameters:
- COUNTER_SIZE, 3, width of counter and initial_value.
- TALLY_LIMIT, 15, win/loss count that ends a game.
- TIMEOUT_W, 16, width of cfg_max_cycles and cycle_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a game when idle, ignored otherwise.
- cfg_init_value  in  COUNTER_SIZE  value to load via INIT; sampled at start.
- cfg_control  in  2  count mode; sampled at start. 00 = +1, 01 = +2, 10 = -1, 11 = -2.
- cfg_max_cycles  in  TIMEOUT_W  RUN-cycle budget before timeout; sampled at start. 0 = no timeout.
- INIT  out  1  load request to the counter game.
- initial_value  out  COUNTER_SIZE  load value.
- control  out  2  count mode to the counter game.
- counter  in  COUNTER_SIZE  observed counter.
- WINNER  in  1  observed win pulse.
- LOSER  in  1  observed loss pulse.
- GAMEOVER  in  1  observed end of game.
- WHO  in  2  observed result. 01 = loser, 10 = winner.
- busy  out  1  high from LOAD through CHECK.
- done  out  1  one-cycle pulse on the cycle DONE is entered.
- result  out  2  latched WHO. 11 = timeout, 00 = none yet.
- win_count  out  4  own tally of WINNER pulses.
- lose_count  out  4  own tally of LOSER pulses.
- mismatch  out  1  sticky error flag.
- cycle_count  out  TIMEOUT_W  cycles spent in RUN.

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All outputs 0: INIT, initial_value, control, busy, done, result, win_count, lose_count, mismatch, cycle_count.
- FSM states: IDLE, LOAD, SETTLE, RUN, CHECK, DONE.
- IDLE:
  - On start, latch the cfg_* inputs, clear win_count, lose_count, mismatch, result and cycle_count, then go to LOAD.
- LOAD (1 cycle):
  - INIT = 1, initial_value = latched value, control = latched mode. Go to SETTLE.
- SETTLE (1 cycle):
  - INIT = 0. Capture prev = counter; the checker is not armed this cycle. Go to RUN.
- RUN, every cycle:
  - Tally: a high WINNER increments win_count; a high LOSER increments lose_count. Both saturate at 15.
  - Counter check: expected = (prev + step) mod 2^COUNTER_SIZE, with step from the latched mode using two's-complement wrap.
    - The cycle after GAMEOVER was high, expected = 0.
    - If counter ≠ expected, set mismatch. mismatch is sticky until the next start.
    - prev <= counter.
  - Pulse check: WINNER and LOSER high together sets mismatch.
  - cycle_count increments.
  - On GAMEOVER = 1: latch result = WHO, go to CHECK.
  - On timeout (cfg_max_cycles ≠ 0 and cycle_count + 1 == cfg_max_cycles), with GAMEOVER low: result = 11, go to DONE. If both happen in the same cycle, GAMEOVER wins.
- CHECK (1 cycle):
  - Set mismatch unless one of these holds:
    - result = 01 and lose_count == TALLY_LIMIT;
    - result = 10 and win_count == TALLY_LIMIT.
  - A WINNER or LOSER pulse arriving in the same cycle as GAMEOVER counts toward the tally before this comparison.
  - Go to DONE.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - result, tallies and mismatch hold until the next start.
- Outputs: busy = 1 in LOAD, SETTLE, RUN and CHECK; 0 otherwise.
- Reset mid-game: returns to IDLE immediately and INIT drops to 0 asynchronously. The counter game itself is not reset by this block.
- start while busy: ignored, no effect.
- All outputs are registered; the latency from start to INIT is 1 cycle.

Test Plan:
- COUNTER_SIZE=3, init 0, control 01: counter runs 0,2,4,6,0… with only LOSER pulses → after 15 losses, result=01, lose_count=15, win_count=0, mismatch=0, done pulses once.
- Init 1, control 01: counter runs 1,3,5,7,1… with only WINNER pulses → result=10, win_count=15, lose_count=0, mismatch=0.
- Init 5, control 10: counter counts down with wrap 0→7 → both tallies advance, lose_count reaches 15 first, result=01, mismatch=0.
- Force the counter input to skip a value in RUN (e.g. 3→5 with control 00) → mismatch=1 and stays 1 through DONE; the next start clears it.
- cfg_max_cycles=20 with the game held without GAMEOVER → result=11, cycle_count=20, done pulse; a start pulse mid-RUN has no effect.
- Assert reset during RUN with INIT low → all outputs 0 on that edge, state IDLE; the next start repeats LOAD with INIT=1 for exactly one cycle.
